// File: rtl/cobertura_pkg.sv
// Definitions shared by the cover actuator and the cover controller bench:
// motion states and the motor direction encoding.
package cobertura_pkg;

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        ABRINDO  = 2'd1,
        FECHANDO = 2'd2,
        PAUSA    = 2'd3
    } estado_t;

    localparam logic DIR_ABRIR  = 1'b1;
    localparam logic DIR_FECHAR = 1'b0;

endpackage

// File: rtl/contador_passo.sv
// Loadable down-counter with enable; o_tc flags that the count has reached zero.
// Load wins over enable, and the count holds at zero until reloaded.
module contador_passo #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_valor,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    assign o_tc = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_valor;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

endmodule

// File: rtl/atuador_cobertura.sv
// Retractable-cover motor plant: turns open/close levels into stepped position
// motion, inserts a motor-off dead-time on reversal and reports the limit switches.
module atuador_cobertura
    import cobertura_pkg::*;
#(
    parameter int CURSO     = 8,
    parameter int PASSO_DIV = 4,
    parameter int PAUSA     = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       abrir,
    input  logic                       fechar,
    output logic                       motor_on,
    output logic                       motor_dir,
    output logic                       e,
    output logic                       d,
    output logic [$clog2(CURSO+1)-1:0] posicao,
    output logic                       conflito
);

    localparam int PW = $clog2(CURSO + 1);
    localparam int SW = (PASSO_DIV > 1) ? $clog2(PASSO_DIV) : 1;
    localparam int ZW = (PAUSA > 1) ? $clog2(PAUSA) : 1;
    localparam logic [PW-1:0] FIM = PW'(CURSO);

    estado_t       r_estado, w_nxt_estado;
    logic          r_dir, w_nxt_dir;
    logic [PW-1:0] r_posicao, w_nxt_pos;
    logic          r_conflito;

    logic w_cmd_abrir, w_cmd_fechar, w_conflito;
    logic w_fim, w_zero;
    logic w_step_load, w_step_en, w_step_tc;
    logic w_pausa_load, w_pausa_en, w_pausa_tc;

    assign w_cmd_abrir  = abrir & ~fechar;
    assign w_cmd_fechar = fechar & ~abrir;
    assign w_conflito   = abrir & fechar;
    assign w_fim        = (r_posicao == FIM);
    assign w_zero       = (r_posicao == '0);

    assign motor_on  = (r_estado == ABRINDO) || (r_estado == FECHANDO);
    assign motor_dir = r_dir;
    assign e         = w_fim;
    assign d         = w_zero;
    assign posicao   = r_posicao;
    assign conflito  = r_conflito;

    assign w_step_en  = motor_on;
    assign w_pausa_en = (r_estado == cobertura_pkg::PAUSA);

    // Counters are loaded with N-1 so the terminal count lands N edges after the load.
    contador_passo #(.W(SW)) u_passo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_step_load),
        .i_valor (SW'(PASSO_DIV - 1)),
        .i_en    (w_step_en),
        .o_tc    (w_step_tc)
    );

    contador_passo #(.W(ZW)) u_pausa (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_pausa_load),
        .i_valor (ZW'(PAUSA - 1)),
        .i_en    (w_pausa_en),
        .o_tc    (w_pausa_tc)
    );

    always_comb begin
        w_nxt_estado = r_estado;
        w_nxt_dir    = r_dir;
        w_nxt_pos    = r_posicao;
        w_step_load  = 1'b0;
        w_pausa_load = 1'b0;
        case (r_estado)
            PARADO: begin
                if (w_cmd_abrir && !w_fim) begin
                    w_nxt_estado = ABRINDO;
                    w_nxt_dir    = DIR_ABRIR;
                    w_step_load  = 1'b1;
                end else if (w_cmd_fechar && !w_zero) begin
                    w_nxt_estado = FECHANDO;
                    w_nxt_dir    = DIR_FECHAR;
                    w_step_load  = 1'b1;
                end
            end
            ABRINDO: begin
                if (w_cmd_fechar) begin
                    w_nxt_estado = cobertura_pkg::PAUSA;
                    w_nxt_dir    = DIR_FECHAR;
                    w_pausa_load = 1'b1;
                end else if (!w_cmd_abrir) begin
                    w_nxt_estado = PARADO;
                end else if (w_step_tc) begin
                    w_nxt_pos   = r_posicao + PW'(1);
                    w_step_load = 1'b1;
                    if (r_posicao == FIM - PW'(1))
                        w_nxt_estado = PARADO;
                end
            end
            FECHANDO: begin
                if (w_cmd_abrir) begin
                    w_nxt_estado = cobertura_pkg::PAUSA;
                    w_nxt_dir    = DIR_ABRIR;
                    w_pausa_load = 1'b1;
                end else if (!w_cmd_fechar) begin
                    w_nxt_estado = PARADO;
                end else if (w_step_tc) begin
                    w_nxt_pos   = r_posicao - PW'(1);
                    w_step_load = 1'b1;
                    if (r_posicao == PW'(1))
                        w_nxt_estado = PARADO;
                end
            end
            default: begin
                // Dead-time: only a conflict cuts it short; other command changes wait.
                if (w_conflito) begin
                    w_nxt_estado = PARADO;
                end else if (w_pausa_tc) begin
                    w_nxt_estado = PARADO;
                    if (r_dir == DIR_ABRIR && w_cmd_abrir && !w_fim) begin
                        w_nxt_estado = ABRINDO;
                        w_step_load  = 1'b1;
                    end else if (r_dir == DIR_FECHAR && w_cmd_fechar && !w_zero) begin
                        w_nxt_estado = FECHANDO;
                        w_step_load  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado   <= PARADO;
            r_dir      <= DIR_FECHAR;
            r_posicao  <= '0;
            r_conflito <= 1'b0;
        end else begin
            r_estado   <= w_nxt_estado;
            r_dir      <= w_nxt_dir;
            r_posicao  <= w_nxt_pos;
            r_conflito <= w_conflito;
        end
    end

endmodule

// File: tb/tb_atuador_cobertura.sv
// Directed bench for the cover actuator with default geometry (CURSO=8,
// PASSO_DIV=4, PAUSA=3); expected values are worked out by hand per edge.
module tb_atuador_cobertura;

    logic       clk;
    logic       rst_n;
    logic       abrir;
    logic       fechar;
    logic       motor_on;
    logic       motor_dir;
    logic       e;
    logic       d;
    logic [3:0] posicao;
    logic       conflito;

    int n_checks = 0;
    int n_errors = 0;

    atuador_cobertura dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abrir     (abrir),
        .fechar    (fechar),
        .motor_on  (motor_on),
        .motor_dir (motor_dir),
        .e         (e),
        .d         (d),
        .posicao   (posicao),
        .conflito  (conflito)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b1;
        abrir  = 1'b0;
        fechar = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_motor_on", 32'(motor_on), 0);
        chk("rst_dir", 32'(motor_dir), 0);
        chk("rst_pos", 32'(posicao), 0);
        chk("rst_d", 32'(d), 1);
        chk("rst_e", 32'(e), 0);
        chk("rst_conflito", 32'(conflito), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Full open: posicao = (t-1)/4 after the t-th edge, done at t = 33.
        abrir = 1'b1;
        for (int t = 1; t <= 33; t++) begin
            tick();
            chk("open_pos", 32'(posicao), 32'((t - 1) / 4));
            chk("open_on", 32'(motor_on), (t < 33) ? 1 : 0);
            if (t == 1) chk("open_dir", 32'(motor_dir), 1);
            if (t == 4) chk("open_d_before", 32'(d), 1);
            if (t == 5) chk("open_d_after", 32'(d), 0);
            if (t == 32) chk("open_e_before", 32'(e), 0);
        end
        chk("open_e", 32'(e), 1);

        // Full close back to zero, then further fechar does nothing.
        abrir  = 1'b0;
        fechar = 1'b1;
        for (int t = 1; t <= 33; t++) begin
            tick();
            chk("close_pos", 32'(posicao), 32'(8 - (t - 1) / 4));
            chk("close_on", 32'(motor_on), (t < 33) ? 1 : 0);
            if (t == 1) chk("close_dir", 32'(motor_dir), 0);
        end
        chk("close_d", 32'(d), 1);
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("close_hold_pos", 32'(posicao), 0);
            chk("close_hold_on", 32'(motor_on), 0);
        end

        // Open to 3, then reverse: 3 edges motor off, then closing, decrement 4 later.
        fechar = 1'b0;
        abrir  = 1'b1;
        for (int t = 0; t < 13; t++) tick();
        chk("rev_pos3", 32'(posicao), 3);
        chk("rev_on_pre", 32'(motor_on), 1);
        abrir  = 1'b0;
        fechar = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("rev_pause_on", 32'(motor_on), 0);
            chk("rev_pause_pos", 32'(posicao), 3);
        end
        tick();
        chk("rev_close_on", 32'(motor_on), 1);
        chk("rev_close_dir", 32'(motor_dir), 0);
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("rev_hold_pos", 32'(posicao), 3);
        end
        tick();
        chk("rev_step_pos", 32'(posicao), 2);

        // Release, reopen, then conflict freezes; clearing fechar resumes without pause.
        fechar = 1'b0;
        tick();
        chk("rel_on", 32'(motor_on), 0);
        chk("rel_pos", 32'(posicao), 2);
        abrir = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        chk("cf_pre_on", 32'(motor_on), 1);
        fechar = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("cf_conflito", 32'(conflito), 1);
            chk("cf_on", 32'(motor_on), 0);
            chk("cf_pos", 32'(posicao), 2);
        end
        fechar = 1'b0;
        tick();
        chk("cf_resume_on", 32'(motor_on), 1);
        chk("cf_resume_dir", 32'(motor_dir), 1);
        chk("cf_clear", 32'(conflito), 0);
        for (int t = 1; t <= 14; t++) begin
            tick();
            chk("cf_run_pos", 32'(posicao), 32'(2 + t / 4));
        end
        chk("mid_on", 32'(motor_on), 1);

        // Async reset between edges at posicao 5.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pos", 32'(posicao), 0);
        chk("arst_d", 32'(d), 1);
        chk("arst_on", 32'(motor_on), 0);
        chk("arst_e", 32'(e), 0);
        abrir = 1'b0;
        #2 rst_n = 1'b1;

        // Short pulse shorter than a step: motion but no position change.
        tick();
        abrir = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("pulse_on", 32'(motor_on), 1);
            chk("pulse_pos", 32'(posicao), 0);
        end
        abrir = 1'b0;
        tick();
        chk("pulse_off", 32'(motor_on), 0);
        chk("pulse_end_pos", 32'(posicao), 0);
        chk("pulse_end_d", 32'(d), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/atuador_cobertura.md
Name: atuador_cobertura

Overview:
- Cycle-accurate model and driver of the retractable-cover motor at the opposite end of the cover controller interface.
- Consumes the controller's open/close commands (abrir, fechar) and moves a position counter in discrete steps.
- Enforces a dead-time on direction reversal.
- Produces the two limit-switch signals the controller reads back: e = fully open, d = fully closed.
- Used as the plant for closed-loop simulation and as the motor sequencer in hardware.

Parameters:
- CURSO, 8, number of position steps between fully closed (0) and fully open (CURSO); must be at least 1.
- PASSO_DIV, 4, clock cycles per position step; must be at least 1.
- PAUSA, 3, dead-time cycles with the motor off before a direct reversal; must be at least 1.

Ports:
- clk, input, 1, single system clock; everything is rising-edge.
- rst_n, input, 1, reset: asynchronous assert, active-low.
- abrir, input, 1, open command from the controller; level-sensitive.
- fechar, input, 1, close command from the controller; level-sensitive.
- motor_on, output, 1, motor energised.
- motor_dir, output, 1, 1 = opening, 0 = closing; valid only while motor_on = 1.
- e, output, 1, open limit switch: 1 iff posicao == CURSO.
- d, output, 1, closed limit switch: 1 iff posicao == 0.
- posicao, output, $clog2(CURSO+1), current position.
- conflito, output, 1, registered; high in every cycle after an edge that sampled abrir & fechar.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = PARADO, posicao = 0, step and pause counters = 0, dir = 0.
  - Outputs: motor_on = 0, motor_dir = 0, d = 1, e = 0, conflito = 0.
  - Reset mid-motion aborts immediately; posicao returns to 0.
- Output decode:
  - motor_on = (state == ABRINDO || state == FECHANDO); motor_dir = dir register.
  - e and d decode combinationally from registered posicao.
- Command decode, per edge:
  - cmd_open = abrir & ~fechar; cmd_close = fechar & ~abrir; both high = conflict (treated as stop).
- PARADO:
  - cmd_open & posicao < CURSO -> ABRINDO, dir = 1, step counter = 0.
  - cmd_close & posicao > 0 -> FECHANDO, dir = 0, step counter = 0.
  - Otherwise stay; no pause is applied when starting from PARADO.
- ABRINDO (FECHANDO symmetric):
  - Step counter counts 0..PASSO_DIV-1; on the edge where it equals PASSO_DIV-1, posicao increments (decrements) and the counter wraps to 0.
  - The first step lands PASSO_DIV edges after the entry edge.
  - The edge that makes posicao == CURSO (0) also moves state -> PARADO; posicao never leaves 0..CURSO.
  - Command released or conflict -> PARADO on that edge; the partial step is discarded and posicao is unchanged.
  - Opposite command alone -> PAUSA: motor off, pause counter = 0, dir latched to the new direction.
- PAUSA:
  - Counts PAUSA edges with motor_on = 0.
  - On the last edge: if the command matching the latched dir is still present and its limit is not reached, enter that moving state with step counter = 0; otherwise -> PARADO.
  - A command change during PAUSA is not re-evaluated until the pause ends.
- Simultaneous events: conflict has priority over every transition except reset.

Decomposition:
- Shared package cobertura_pkg:
  - state enum {PARADO, ABRINDO, FECHANDO, PAUSA}.
  - Constants DIR_ABRIR = 1 and DIR_FECHAR = 0.
  - This package is also used by the controller bench.
- One sub-module, contador_passo: parameterised down-counter with load, enable and terminal-count output, instantiated twice (step timing and pause timing).

Test Plan:
- Reset, then abrir = 1 held from edge k -> motor_on = 1, motor_dir = 1 from edge k; posicao = 1 at k+4; posicao = 8, e = 1, motor_on = 0 at k+32; d = 0 from k+4.
- From posicao = 8, fechar = 1 -> posicao = 0 and d = 1 after 32 edges; further fechar causes no motion and posicao stays 0.
- Opening at posicao = 3, switch to fechar only -> motor_on = 0 for 3 edges (PAUSA), then FECHANDO with motor_dir = 0; first decrement 4 edges later, posicao = 2.
- abrir = fechar = 1 while ABRINDO -> conflito = 1 and motor_on = 0 from the next edge; posicao is frozen; clearing fechar restarts ABRINDO with no pause.
- rst_n pulsed low between clock edges mid-travel at posicao = 5 -> outputs reset immediately (posicao = 0, d = 1, motor_on = 0) with no clock edge required.
- abrir pulsed for 3 edges (less than PASSO_DIV) -> motor_on high for 3 cycles, posicao unchanged, state returns to PARADO.
